// File: rtl/bsg_tag_tx_pkg.sv
// Shared types for the bsg_tag serial transmitter: FSM states, header layout
// and the header-length helper.
package bsg_tag_tx_pkg;

  localparam int els_gp               = 1024;
  localparam int max_payload_width_gp = 128;
  localparam int lg_els_gp            = $clog2(els_gp);
  localparam int len_width_gp         = $clog2(max_payload_width_gp + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    MRST,
    GAP
  } tx_state_e;

  // Field order puts start in bit 0, so the LSB-first shift sends it first.
  typedef struct packed {
    logic [len_width_gp-1:0] len;
    logic                    data_not_reset;
    logic [lg_els_gp-1:0]    node_id;
    logic                    start;
  } tag_header_s;

  function automatic int header_len(input int lg_els, input int len_width);
    return 2 + lg_els + len_width;
  endfunction

endpackage

// File: rtl/bsg_tag_tx_shifter.sv
// Loadable LSB-first shift register with a per-state bit counter; done_o flags
// the step that emits bit number last_i, and that step rewinds the counter.
module bsg_tag_tx_shifter #(
  parameter int width_p     = 148,
  parameter int cnt_width_p = 9
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_i,
  input  logic [width_p-1:0]     load_data_i,
  input  logic                   step_i,
  input  logic [cnt_width_p-1:0] last_i,
  output logic                   bit_o,
  output logic                   done_o
);

  logic [width_p-1:0]     data_r;
  logic [cnt_width_p-1:0] count_r;

  assign bit_o  = data_r[0];
  assign done_o = (count_r == last_i);

  // NOTE: the shift register is ordinary flop state, not a RAM, so it takes the
  // async reset like everything else and never exposes stale command bits.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (load_i) begin
      data_r  <= load_data_i;
      count_r <= '0;
    end else if (step_i) begin
      data_r  <= data_r >> 1;
      count_r <= done_o ? '0 : count_r + cnt_width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag serial transmitter: accepts one command per handshake and drives the
// registered tag_data_o/tag_en_o pair, one bit per clk_i cycle.
module bsg_tag_serial_tx
  import bsg_tag_tx_pkg::*;
#(
  parameter int els_p               = els_gp,
  parameter int max_payload_width_p = max_payload_width_gp,
  parameter int reset_ones_p        = 256,
  parameter int gap_zeros_p         = 2,
  parameter int lg_els_lp           = $clog2(els_p),
  parameter int len_width_lp        = $clog2(max_payload_width_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic                           master_reset_i,
  input  logic [lg_els_lp-1:0]           node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [len_width_lp-1:0]        len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           tag_en_o,
  output logic                           busy_o
);

  localparam int hdr_len_lp     = header_len(lg_els_lp, len_width_lp);
  localparam int frame_width_lp = hdr_len_lp + max_payload_width_p;
  localparam int cnt_max_a_lp   = (reset_ones_p > frame_width_lp) ? reset_ones_p : frame_width_lp;
  localparam int cnt_max_lp     = (gap_zeros_p > cnt_max_a_lp) ? gap_zeros_p : cnt_max_a_lp;
  localparam int cnt_width_lp   = $clog2(cnt_max_lp + 1);

  typedef logic [cnt_width_lp-1:0] cnt_t;
  typedef logic [len_width_lp-1:0] len_t;

  typedef struct packed {
    len_t                 len;
    logic                 data_not_reset;
    logic [lg_els_lp-1:0] node_id;
    logic                 start;
  } header_s;

  tx_state_e state_r, state_n;
  len_t      len_r, len_sat;
  header_s   hdr;
  cnt_t      last;
  logic      accept, step, shift_bit, done, data_n, en_n;

  assign ready_o = (state_r == IDLE);
  assign busy_o  = ~ready_o;
  assign accept  = v_i & ready_o;

  // The saturated length is both the one transmitted and the one that ends PAY.
  assign len_sat = (len_i > len_t'(max_payload_width_p)) ? len_t'(max_payload_width_p) : len_i;
  assign hdr     = '{len: len_sat, data_not_reset: data_not_reset_i, node_id: node_id_i, start: 1'b1};

  bsg_tag_tx_shifter #(
    .width_p    (frame_width_lp),
    .cnt_width_p(cnt_width_lp)
  ) shifter (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (accept),
    .load_data_i({payload_i, hdr}),
    .step_i     (step),
    .last_i     (last),
    .bit_o      (shift_bit),
    .done_o     (done)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_r;
    step    = 1'b0;
    data_n  = 1'b0;
    en_n    = 1'b0;
    last    = '0;
    case (state_r)
      IDLE: begin
        if (accept) state_n = master_reset_i ? MRST : HDR;
      end
      HDR: begin
        step   = 1'b1;
        data_n = shift_bit;
        en_n   = 1'b1;
        last   = cnt_t'(hdr_len_lp - 1);
        if (done) state_n = (len_r != '0) ? PAY : GAP;
      end
      PAY: begin
        step   = 1'b1;
        data_n = shift_bit;
        en_n   = 1'b1;
        last   = cnt_t'(len_r) - cnt_t'(1);
        if (done) state_n = GAP;
      end
      MRST: begin
        step   = 1'b1;
        data_n = 1'b1;
        en_n   = 1'b1;
        last   = cnt_t'(reset_ones_p - 1);
        if (done) state_n = GAP;
      end
      GAP: begin
        step   = 1'b1;
        en_n   = 1'b1;
        last   = cnt_t'(gap_zeros_p - 1);
        if (done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the order of these statements cannot change behaviour.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      len_r      <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
    end else begin
      state_r    <= state_n;
      tag_data_o <= data_n;
      tag_en_o   <= en_n;
      if (accept) len_r <= len_sat;
    end
  end

endmodule
